// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl - frame-synchronous game state controller for the 1024x768 arena.
//
// Sequences START -> GAME -> PLAYER_1 / PLAYER_2 -> START, keeps both scores,
// runs the round timer and the per-victim hit cooldown. Every state, score
// and timer update happens only in a frame_tick cycle, so the screen never
// changes mid-frame.
//
// State encoding: START=0, GAME=1, PLAYER_1=2, PLAYER_2=3.
//
// Ports:
//   clk         in   65 MHz pixel clock
//   rst_n       in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per frame (VBLANK start)
//   start_btn   in   raw asynchronous start button (level)
//   p1_hit      in   pulse: player 1 was hit (point to player 2)
//   p2_hit      in   pulse: player 2 was hit (point to player 1)
//   pause_btn   in   raw asynchronous pause button (only with GAME_PAUSE_EN)
//   state       out  current game state
//   p1_score    out  player 1 score
//   p2_score    out  player 2 score
//   frames_left out  remaining round frames, 0 outside GAME
//   game_active out  high while in GAME (and not paused)
//
// Optional feature macro: GAME_PAUSE_EN (adds pause_btn and a pause toggle).
// -----------------------------------------------------------------------------
module game_ctrl #(
   parameter int WIN_SCORE    = 5,
   parameter int ROUND_FRAMES = 3600,
   parameter int SHOW_FRAMES  = 180,
   parameter int HIT_COOLDOWN = 30,
   parameter int SCORE_W      = 4,
   parameter int TIMER_W      = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               p1_hit,
   input  logic               p2_hit,
`ifdef GAME_PAUSE_EN
   input  logic               pause_btn,
`endif
   output logic [1:0]         state,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [TIMER_W-1:0] frames_left,
   output logic               game_active
);

   typedef enum logic [1:0] {
      ST_START    = 2'd0,
      ST_GAME     = 2'd1,
      ST_PLAYER_1 = 2'd2,
      ST_PLAYER_2 = 2'd3
   } state_t;

   // show counter is at least 5 bits so the 16-tick start guard always fits
   localparam int CD_W   = $clog2(HIT_COOLDOWN + 1);
   localparam int SHOW_W = ($clog2(SHOW_FRAMES + 1) > 5) ? $clog2(SHOW_FRAMES + 1) : 5;

   localparam logic [SCORE_W-1:0] WIN_V   = SCORE_W'(WIN_SCORE);
   localparam logic [TIMER_W-1:0] ROUND_V = TIMER_W'(ROUND_FRAMES);
   localparam logic [CD_W-1:0]    CD_V    = CD_W'(HIT_COOLDOWN);
   localparam logic [SHOW_W-1:0]  SHOW_V  = SHOW_W'(SHOW_FRAMES);
   localparam logic [SHOW_W-1:0]  GUARD_V = SHOW_W'(16);

   // saturating score increment
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      if (v == {SCORE_W{1'b1}}) sat_inc = v;
      else                      sat_inc = v + SCORE_W'(1);
   endfunction

   logic start_meta_r, start_sync_r, start_prev_r, start_rise_r;
   logic start_f_r, hit1_f_r, hit2_f_r;

   state_t             state_r, state_nxt_s;
   logic [SCORE_W-1:0] p1_score_r, p2_score_r, p1_nxt_s, p2_nxt_s, p1_new_s, p2_new_s;
   logic [TIMER_W-1:0] frames_r, frames_nxt_s, frames_dec_s;
   logic [CD_W-1:0]    cd1_r, cd2_r, cd1_nxt_s, cd2_nxt_s, cd1_dec_s, cd2_dec_s;
   logic [SHOW_W-1:0]  show_r, show_nxt_s, show_inc_s;
   logic               active_r, active_nxt_s;
   logic               acc1_s, acc2_s, run_s;

`ifdef GAME_PAUSE_EN
   logic pause_meta_r, pause_sync_r, pause_prev_r, pause_rise_r;
   logic pause_f_r, paused_r, paused_nxt_s;

   // pause button synchroniser and rising-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pause_meta_r <= 1'b0;
         pause_sync_r <= 1'b0;
         pause_prev_r <= 1'b0;
         pause_rise_r <= 1'b0;
      end else begin
         pause_meta_r <= pause_btn;
         pause_sync_r <= pause_meta_r;
         pause_prev_r <= pause_sync_r;
         pause_rise_r <= pause_sync_r & ~pause_prev_r;
      end
   end

   // sticky pause request, an edge landing on a tick is kept for the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          pause_f_r <= 1'b0;
      else if (frame_tick) pause_f_r <= pause_rise_r;
      else                 pause_f_r <= pause_f_r | pause_rise_r;
   end

   assign run_s = ~paused_r;
`else
   assign run_s = 1'b1;
`endif

   // start button synchroniser and registered rising-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_meta_r <= 1'b0;
         start_sync_r <= 1'b0;
         start_prev_r <= 1'b0;
         start_rise_r <= 1'b0;
      end else begin
         start_meta_r <= start_btn;
         start_sync_r <= start_meta_r;
         start_prev_r <= start_sync_r;
         start_rise_r <= start_sync_r & ~start_prev_r;
      end
   end

   // sticky event flags: on a tick they reload with the coincident event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_f_r <= 1'b0;
         hit1_f_r  <= 1'b0;
         hit2_f_r  <= 1'b0;
      end else if (frame_tick) begin
         start_f_r <= start_rise_r;
         hit1_f_r  <= p1_hit;
         hit2_f_r  <= p2_hit;
      end else begin
         start_f_r <= start_f_r | start_rise_r;
         hit1_f_r  <= hit1_f_r | p1_hit;
         hit2_f_r  <= hit2_f_r | p2_hit;
      end
   end

   // next-state, score, timer and cooldown evaluation for the coming tick
   always_comb begin
      state_nxt_s  = state_r;
      p1_nxt_s     = p1_score_r;
      p2_nxt_s     = p2_score_r;
      frames_nxt_s = frames_r;
      cd1_nxt_s    = cd1_r;
      cd2_nxt_s    = cd2_r;
      show_nxt_s   = show_r;
      cd1_dec_s    = (cd1_r != '0) ? cd1_r - CD_W'(1) : '0;
      cd2_dec_s    = (cd2_r != '0) ? cd2_r - CD_W'(1) : '0;
      frames_dec_s = (frames_r != '0) ? frames_r - TIMER_W'(1) : '0;
      show_inc_s   = (show_r == {SHOW_W{1'b1}}) ? show_r : show_r + SHOW_W'(1);
      acc1_s       = hit1_f_r & (cd1_dec_s == '0);
      acc2_s       = hit2_f_r & (cd2_dec_s == '0);
      p2_new_s     = acc1_s ? sat_inc(p2_score_r) : p2_score_r;
      p1_new_s     = acc2_s ? sat_inc(p1_score_r) : p1_score_r;

      case (state_r)
         ST_START: begin
            show_nxt_s = '0;
            if (start_f_r) begin
               state_nxt_s  = ST_GAME;
               p1_nxt_s     = '0;
               p2_nxt_s     = '0;
               frames_nxt_s = ROUND_V;
               cd1_nxt_s    = '0;
               cd2_nxt_s    = '0;
            end else begin
               frames_nxt_s = '0;
            end
         end
         ST_GAME: begin
            show_nxt_s = '0;
            if (run_s) begin
               cd1_nxt_s    = acc1_s ? CD_V : cd1_dec_s;
               cd2_nxt_s    = acc2_s ? CD_V : cd2_dec_s;
               p1_nxt_s     = p1_new_s;
               p2_nxt_s     = p2_new_s;
               frames_nxt_s = frames_dec_s;
               // a tie at the winning score drops both back one point
               if ((p1_new_s == WIN_V) && (p2_new_s == WIN_V)) begin
                  p1_nxt_s = WIN_V - SCORE_W'(1);
                  p2_nxt_s = WIN_V - SCORE_W'(1);
               end else if (p1_new_s == WIN_V) begin
                  state_nxt_s  = ST_PLAYER_1;
                  frames_nxt_s = '0;
               end else if (p2_new_s == WIN_V) begin
                  state_nxt_s  = ST_PLAYER_2;
                  frames_nxt_s = '0;
               end else if (frames_dec_s == '0) begin
                  frames_nxt_s = '0;
                  if (p1_new_s > p2_new_s)      state_nxt_s = ST_PLAYER_1;
                  else if (p2_new_s > p1_new_s) state_nxt_s = ST_PLAYER_2;
                  else                          state_nxt_s = ST_START;
               end else begin
                  state_nxt_s = ST_GAME;
               end
            end else begin
               state_nxt_s = ST_GAME;
            end
         end
         ST_PLAYER_1, ST_PLAYER_2: begin
            frames_nxt_s = '0;
            // start only counts once the guard has elapsed, so a held
            // button cannot bounce straight through the winner screen
            if (show_inc_s >= SHOW_V) begin
               state_nxt_s = ST_START;
               show_nxt_s  = '0;
            end else if (start_f_r && (show_r >= GUARD_V)) begin
               state_nxt_s = ST_START;
               show_nxt_s  = '0;
            end else begin
               show_nxt_s = show_inc_s;
            end
         end
         default: begin
            state_nxt_s  = ST_START;
            frames_nxt_s = '0;
            show_nxt_s   = '0;
         end
      endcase

`ifdef GAME_PAUSE_EN
      if ((state_r == ST_GAME) && (state_nxt_s == ST_GAME)) paused_nxt_s = paused_r ^ pause_f_r;
      else                                                   paused_nxt_s = 1'b0;
      active_nxt_s = (state_nxt_s == ST_GAME) & ~paused_nxt_s;
`else
      active_nxt_s = (state_nxt_s == ST_GAME);
`endif
   end

   // frame-synchronous state register, only loads in a frame_tick cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_START;
         p1_score_r <= '0;
         p2_score_r <= '0;
         frames_r   <= '0;
         cd1_r      <= '0;
         cd2_r      <= '0;
         show_r     <= '0;
         active_r   <= 1'b0;
`ifdef GAME_PAUSE_EN
         paused_r   <= 1'b0;
`endif
      end else if (frame_tick) begin
         state_r    <= state_nxt_s;
         p1_score_r <= p1_nxt_s;
         p2_score_r <= p2_nxt_s;
         frames_r   <= frames_nxt_s;
         cd1_r      <= cd1_nxt_s;
         cd2_r      <= cd2_nxt_s;
         show_r     <= show_nxt_s;
         active_r   <= active_nxt_s;
`ifdef GAME_PAUSE_EN
         paused_r   <= paused_nxt_s;
`endif
      end else begin
         state_r <= state_r;
      end
   end

   assign state       = state_r;
   assign p1_score    = p1_score_r;
   assign p2_score    = p2_score_r;
   assign frames_left = frames_r;
   assign game_active = active_r;

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl - self-checking bench for game_ctrl (default parameters).
// Expected output records are queued when stimulus is applied and compared
// field by field once the DUT has taken the tick.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

   localparam logic [1:0] S_START = 2'd0;
   localparam logic [1:0] S_GAME  = 2'd1;
   localparam logic [1:0] S_P1    = 2'd2;
   localparam logic [1:0] S_P2    = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        start_btn = 1'b0;
   logic        p1_hit = 1'b0;
   logic        p2_hit = 1'b0;
`ifdef GAME_PAUSE_EN
   logic        pause_btn = 1'b0;
`endif
   logic [1:0]  state;
   logic [3:0]  p1_score, p2_score;
   logic [11:0] frames_left;
   logic        game_active;

   game_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
      .p1_hit(p1_hit), .p2_hit(p2_hit),
`ifdef GAME_PAUSE_EN
      .pause_btn(pause_btn),
`endif
      .state(state), .p1_score(p1_score), .p2_score(p2_score),
      .frames_left(frames_left), .game_active(game_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  st;
      logic [3:0]  s1, s2;
      logic [11:0] fl;
      logic        act;
   } exp_t;

   typedef struct {
      bit          h1, h2, coin;
      logic [1:0]  st;
      logic [3:0]  s1, s2;
      logic [11:0] fl;
   } vec_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    checks = 0;
   int    failures = 0;
   int    exp_fl = 0;
   vec_t  vt[7];

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
      end
   endtask

   task automatic expect_out(input string nm, input logic [1:0] st, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [11:0] fl, input logic act);
      exp_t e;
      e.st = st; e.s1 = s1; e.s2 = s2; e.fl = fl; e.act = act;
      sb_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic check_out();
      exp_t  e;
      string nm;
      if (sb_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL scoreboard actual=empty required=entry");
      end else begin
         e  = sb_q.pop_front();
         nm = nm_q.pop_front();
         cmp(nm, "state", {30'd0, state}, {30'd0, e.st});
         cmp(nm, "p1_score", {28'd0, p1_score}, {28'd0, e.s1});
         cmp(nm, "p2_score", {28'd0, p2_score}, {28'd0, e.s2});
         cmp(nm, "frames_left", {20'd0, frames_left}, {20'd0, e.fl});
         cmp(nm, "game_active", {31'd0, game_active}, {31'd0, e.act});
      end
   endtask

   // hits either one cycle before the tick or in the tick cycle itself
   task automatic tick_with(input bit h1, input bit h2, input bit coin);
      if (!coin && (h1 || h2)) begin
         @(negedge clk); p1_hit = h1; p2_hit = h2;
         @(negedge clk); p1_hit = 1'b0; p2_hit = 1'b0;
      end
      @(negedge clk);
      frame_tick = 1'b1;
      if (coin) begin p1_hit = h1; p2_hit = h2; end
      @(negedge clk);
      frame_tick = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic game_ticks(input int n);
      repeat (n) tick_with(1'b0, 1'b0, 1'b0);
      exp_fl -= n;
   endtask

   task automatic hit_tick(input bit h1, input bit h2);
      tick_with(h1, h2, 1'b0);
      exp_fl -= 1;
   endtask

   task automatic press_start();
      @(negedge clk); start_btn = 1'b1;
      repeat (10) @(negedge clk);
      start_btn = 1'b0;
      repeat (4) @(negedge clk);
   endtask

`ifdef GAME_PAUSE_EN
   task automatic press_pause();
      @(negedge clk); pause_btn = 1'b1;
      repeat (10) @(negedge clk);
      pause_btn = 1'b0;
      repeat (4) @(negedge clk);
   endtask
`endif

   task automatic start_game(input string nm);
      press_start();
      expect_out(nm, S_GAME, 4'd0, 4'd0, 12'd3600, 1'b1);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();
      exp_fl = 3600;
   endtask

   initial begin
      //        h1 h2 coin  state   s1    s2    frames
      vt[0] = '{1'b0, 1'b1, 1'b1, S_GAME, 4'd0, 4'd0, 12'd3598};
      vt[1] = '{1'b0, 1'b0, 1'b0, S_GAME, 4'd1, 4'd0, 12'd3597};
      vt[2] = '{1'b1, 1'b0, 1'b0, S_GAME, 4'd1, 4'd1, 12'd3596};
      vt[3] = '{1'b1, 1'b0, 1'b0, S_GAME, 4'd1, 4'd1, 12'd3595};
      vt[4] = '{1'b1, 1'b0, 1'b0, S_GAME, 4'd1, 4'd1, 12'd3594};
      vt[5] = '{1'b0, 1'b1, 1'b0, S_GAME, 4'd1, 4'd1, 12'd3593};
      vt[6] = '{1'b1, 1'b1, 1'b0, S_GAME, 4'd1, 4'd1, 12'd3592};

      // reset values
      repeat (3) @(negedge clk);
      expect_out("reset", S_START, 4'd0, 4'd0, 12'd0, 1'b0);
      check_out();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // start goes through the synchroniser, nothing moves before a tick
      press_start();
      expect_out("pre_tick", S_START, 4'd0, 4'd0, 12'd0, 1'b0);
      check_out();
      expect_out("enter_game", S_GAME, 4'd0, 4'd0, 12'd3600, 1'b1);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();
      expect_out("first_dec", S_GAME, 4'd0, 4'd0, 12'd3599, 1'b1);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();
      exp_fl = 3599;

      // vector table: coincident hit deferred, cooldown blocks repeats
      for (int i = 0; i < 7; i++) begin
         expect_out($sformatf("vec%0d", i), vt[i].st, vt[i].s1, vt[i].s2, vt[i].fl, 1'b1);
         tick_with(vt[i].h1, vt[i].h2, vt[i].coin);
         check_out();
      end
      exp_fl = 3592;

      // build 3/2, then reset mid-game takes effect asynchronously
      game_ticks(30); hit_tick(1'b0, 1'b1);
      game_ticks(30); hit_tick(1'b1, 1'b0);
      game_ticks(30); hit_tick(1'b0, 1'b1);
      expect_out("score_3_2", S_GAME, 4'd3, 4'd2, 12'(exp_fl), 1'b1);
      check_out();
      @(negedge clk); rst_n = 1'b0; #1;
      expect_out("async_reset", S_START, 4'd0, 4'd0, 12'd0, 1'b0);
      check_out();
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // player 1 wins with five spaced hits, winner screen held 180 ticks
      start_game("game2");
      for (int i = 1; i <= 5; i++) begin
         if (i > 1) game_ticks(30);
         if (i == 5) expect_out($sformatf("p1_pt%0d", i), S_P1, 4'(i), 4'd0, 12'd0, 1'b0);
         else        expect_out($sformatf("p1_pt%0d", i), S_GAME, 4'(i), 4'd0, 12'(exp_fl - 1), 1'b1);
         hit_tick(1'b0, 1'b1);
         check_out();
      end
      tick_with(1'b1, 1'b0, 1'b0);
      expect_out("win_hit_ignored", S_P1, 4'd5, 4'd0, 12'd0, 1'b0);
      check_out();
      repeat (178) tick_with(1'b0, 1'b0, 1'b0);
      expect_out("show_179", S_P1, 4'd5, 4'd0, 12'd0, 1'b0);
      check_out();
      expect_out("show_180", S_START, 4'd5, 4'd0, 12'd0, 1'b0);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();

      // tie at the winning score, then timeout with equal scores
      start_game("game3");
`ifdef GAME_PAUSE_EN
      press_pause();
      expect_out("pause_on", S_GAME, 4'd0, 4'd0, 12'(exp_fl - 1), 1'b0);
      hit_tick(1'b0, 1'b0);
      check_out();
      repeat (100) tick_with(1'b1, 1'b1, 1'b0);
      expect_out("paused_100", S_GAME, 4'd0, 4'd0, 12'(exp_fl), 1'b0);
      check_out();
      press_pause();
      expect_out("pause_off", S_GAME, 4'd0, 4'd0, 12'(exp_fl), 1'b1);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();
`endif
      for (int r = 1; r <= 5; r++) begin
         if (r > 1) game_ticks(30);
         expect_out($sformatf("both_%0d", r), S_GAME, (r == 5) ? 4'd4 : 4'(r),
                    (r == 5) ? 4'd4 : 4'(r), 12'(exp_fl - 1), 1'b1);
         hit_tick(1'b1, 1'b1);
         check_out();
      end
      press_start();
      game_ticks(2);
      expect_out("start_in_game", S_GAME, 4'd4, 4'd4, 12'(exp_fl), 1'b1);
      check_out();
      game_ticks(exp_fl - 1);
      expect_out("tie_fl1", S_GAME, 4'd4, 4'd4, 12'd1, 1'b1);
      check_out();
      expect_out("tie_timeout", S_START, 4'd4, 4'd4, 12'd0, 1'b0);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();

      // timeout with 3/1 goes to player 1; start is guarded for 16 ticks
      start_game("game4");
      hit_tick(1'b0, 1'b1); game_ticks(30);
      hit_tick(1'b0, 1'b1); game_ticks(30);
      hit_tick(1'b0, 1'b1);
      hit_tick(1'b1, 1'b0);
      expect_out("score_3_1", S_GAME, 4'd3, 4'd1, 12'(exp_fl), 1'b1);
      check_out();
      game_ticks(exp_fl - 1);
      expect_out("to_fl1", S_GAME, 4'd3, 4'd1, 12'd1, 1'b1);
      check_out();
      expect_out("timeout_p1", S_P1, 4'd3, 4'd1, 12'd0, 1'b0);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();
      press_start();
      repeat (5) tick_with(1'b0, 1'b0, 1'b0);
      expect_out("start_guarded", S_P1, 4'd3, 4'd1, 12'd0, 1'b0);
      check_out();
      repeat (12) tick_with(1'b0, 1'b0, 1'b0);
      press_start();
      expect_out("start_after_guard", S_START, 4'd3, 4'd1, 12'd0, 1'b0);
      tick_with(1'b0, 1'b0, 1'b0);
      check_out();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
